// File: rtl/prover_shuffle_v_mc.sv
// Multi-channel, round-aware V-table (un)shuffle with a PL_LAT-deep output pipeline.
// Each rising edge of en captures all channels, permutes the active prefix and zeroes the rest.
module prover_shuffle_v_mc #(
  parameter int nInBits   = 3,
  parameter int nChannels = 1,
  parameter int PL_LAT    = 1,
  parameter int F_NBITS   = 16,
  parameter int ngates    = 1 << nInBits,
  localparam int RW       = $clog2(nInBits + 1),
  localparam int NE       = nChannels * ngates
) (
  input  logic                           clk,
  input  logic                           rstb,
  input  logic                           en,
  input  logic                           restart,
  input  logic                           inverse,
  input  logic [NE-1:0][F_NBITS-1:0]     v_in,
  output logic [NE-1:0][F_NBITS-1:0]     v_out,
  output logic                           ready,
  output logic                           ready_pulse,
  output logic [RW-1:0]                  round
);

  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam int CW = $clog2(PL_LAT + 1);

  if (ngates != (1 << nInBits) || PL_LAT < 1 || nChannels < 1 || nInBits < 1) begin : g_param_error
    $error("prover_shuffle_v_mc: illegal parameter set");
  end

  logic                       en_dly;
  logic                       inc;
  logic                       ready_dly;
  logic [CW-1:0]              lat_cnt;
  logic [RW-1:0]              op_round;
  logic [NE-1:0][F_NBITS-1:0] perm;
  logic [PL_LAT-1:0]          ld;
  logic [IW-1:0]              src;
  logic [IW-1:0]              dst;
  int unsigned                len;
  int unsigned                half;
  int unsigned                sel;

  assign inc         = en & ~en_dly;
  assign op_round    = restart ? '0 : round;
  assign ready       = ~inc & (lat_cnt == CW'(PL_LAT));
  assign ready_pulse = ready & ~ready_dly;

  // Source-indexed form of the per-channel permutation; len==1 is a plain copy of entry 0.
  always_comb begin
    perm = '0;
    len  = ngates >> op_round;
    half = len / 2;
    sel  = 0;
    src  = '0;
    dst  = '0;
    for (int unsigned c = 0; c < nChannels; c++) begin
      for (int unsigned k = 0; k < ngates; k++) begin
        if (k < len) begin
          if (len == 1)
            sel = 0;
          else if (!inverse)
            sel = (k < half) ? 2 * k : 2 * (k - half) + 1;
          else
            sel = ((k % 2) == 1) ? half + k / 2 : k / 2;
          src       = IW'(c * ngates + sel);
          dst       = IW'(c * ngates + k);
          perm[dst] = v_in[src];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      en_dly    <= 1'b1;
      ready_dly <= 1'b1;
      lat_cnt   <= CW'(PL_LAT);
      round     <= '0;
    end else begin
      en_dly    <= en;
      ready_dly <= ready;
      if (inc) begin
        lat_cnt <= CW'(1);
        round   <= (op_round == RW'(nInBits)) ? RW'(nInBits) : op_round + RW'(1);
      end else if (lat_cnt != CW'(PL_LAT)) begin
        lat_cnt <= lat_cnt + CW'(1);
      end
    end
  end

  // Stage s loads only when stage s-1 holds a fresh result, so back-to-back ops stay ordered.
  assign ld[0] = inc;

  if (PL_LAT > 1) begin : g_vld
    logic [PL_LAT-2:0] vld_q;
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) vld_q <= '0;
      else       vld_q <= ld[PL_LAT-2:0];
    end
    assign ld[PL_LAT-1:1] = vld_q;
  end

  for (genvar s = 0; s < PL_LAT; s++) begin : g_stg
    logic [NE-1:0][F_NBITS-1:0] q;
    logic [NE-1:0][F_NBITS-1:0] d;
    if (s == 0) begin : g_src
      assign d = perm;
    end else begin : g_src
      assign d = g_stg[s-1].q;
    end
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)      q <= '0;
      else if (ld[s]) q <= d;
    end
  end

  assign v_out = g_stg[PL_LAT-1].q;

endmodule

// File: tb/tb_prover_shuffle_v_mc.sv
// Directed scoreboard bench for prover_shuffle_v_mc (nInBits=3, nChannels=2, PL_LAT=2).
module tb_prover_shuffle_v_mc;

  localparam int NIB = 3;
  localparam int NCH = 2;
  localparam int LAT = 2;
  localparam int FW  = 16;
  localparam int NG  = 1 << NIB;
  localparam int NE  = NCH * NG;
  localparam int VW  = NE * FW;
  localparam int RW  = $clog2(NIB + 1);

  typedef logic [NE-1:0][FW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rstb = 1'b1;
  logic          en = 1'b0;
  logic          restart = 1'b0;
  logic          inverse = 1'b0;
  vec_t          v_in = '0;
  vec_t          v_out;
  logic          ready;
  logic          ready_pulse;
  logic [RW-1:0] round;

  always #5 clk = ~clk;

  prover_shuffle_v_mc #(
    .nInBits  (NIB),
    .nChannels(NCH),
    .PL_LAT   (LAT),
    .F_NBITS  (FW)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .en         (en),
    .restart    (restart),
    .inverse    (inverse),
    .v_in       (v_in),
    .v_out      (v_out),
    .ready      (ready),
    .ready_pulse(ready_pulse),
    .round      (round)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tb_round = 0;
  vec_t exp_q[$];
  int   due_q[$];
  vec_t cur_exp = '0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Destination-indexed reference permutation.
  function automatic vec_t model(input vec_t vin, input int r, input bit inv);
    vec_t o;
    int   len;
    int   h;
    o   = '0;
    len = NG >> r;
    h   = len / 2;
    for (int c = 0; c < NCH; c++) begin
      if (len == 1) begin
        o[c*NG] = vin[c*NG];
      end else begin
        for (int j = 0; j < h; j++) begin
          if (!inv) begin
            o[c*NG+j]   = vin[c*NG+2*j];
            o[c*NG+h+j] = vin[c*NG+2*j+1];
          end else begin
            o[c*NG+2*j]   = vin[c*NG+j];
            o[c*NG+2*j+1] = vin[c*NG+h+j];
          end
        end
      end
    end
    return o;
  endfunction

  function automatic vec_t pattern(input int m0, input int a0, input int m1, input int a1);
    vec_t v;
    for (int i = 0; i < NG; i++) begin
      v[i]    = FW'(m0 * (i + 1) + a0);
      v[NG+i] = FW'(m1 * (i + 1) + a1);
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      cur_exp = exp_q.pop_front();
      due_q.delete(0);
    end
    chk("v_out", v_out, cur_exp);
  endtask

  task automatic launch(input bit rs, input bit inv);
    int op;
    op      = rs ? 0 : tb_round;
    restart = rs;
    inverse = inv;
    en      = 1'b1;
    exp_q.push_back(model(v_in, op, inv));
    due_q.push_back(cyc + LAT);
    tb_round = (op + 1 > NIB) ? NIB : op + 1;
    #1;
    chk("ready_inc", VW'(ready), VW'(0));
    chk("pulse_inc", VW'(ready_pulse), VW'(0));
  endtask

  task automatic full_op(input bit rs, input bit inv);
    launch(rs, inv);
    step();
    en = 1'b0;
    #1;
    chk("ready_busy", VW'(ready), VW'(0));
    chk("round", VW'(round), VW'(tb_round));
    step();
    chk("ready_done", VW'(ready), VW'(1));
    chk("pulse_done", VW'(ready_pulse), VW'(1));
    step();
    chk("pulse_once", VW'(ready_pulse), VW'(0));
    chk("ready_hold", VW'(ready), VW'(1));
  endtask

  initial begin
    // 1. reset with en held high
    en   = 1'b1;
    v_in = pattern(1, 0, 10, 0);
    #2 rstb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    #1;
    chk("rst_vout", v_out, '0);
    chk("rst_ready", VW'(ready), VW'(1));
    chk("rst_pulse", VW'(ready_pulse), VW'(0));
    chk("rst_round", VW'(round), VW'(0));
    step();
    step();
    chk("en_held_ready", VW'(ready), VW'(1));
    chk("en_held_round", VW'(round), VW'(0));
    en = 1'b0;
    step();

    // 2. restart, unshuffle, len=8
    full_op(1'b1, 1'b0);
    chk("t2_ch0_1", VW'(v_out[1]), VW'(3));
    chk("t2_ch1_4", VW'(v_out[NG+4]), VW'(20));
    step();

    // 3. successive rounds, then saturation
    full_op(1'b0, 1'b0);
    chk("t3_ch0_2", VW'(v_out[2]), VW'(2));
    chk("t3_ch0_4", VW'(v_out[4]), VW'(0));
    chk("t3_round2", VW'(round), VW'(2));
    step();
    full_op(1'b0, 1'b0);
    chk("t3_ch0_1", VW'(v_out[1]), VW'(2));
    step();
    full_op(1'b0, 1'b0);
    chk("t3_round3", VW'(round), VW'(3));
    step();
    full_op(1'b0, 1'b0);
    chk("t3_sat_round", VW'(round), VW'(3));
    chk("t3_sat_ch0_0", VW'(v_out[0]), VW'(1));
    chk("t3_sat_ch0_1", VW'(v_out[1]), VW'(0));
    chk("t3_sat_ch1_0", VW'(v_out[NG]), VW'(10));
    step();

    // 4. restart, shuffle, len=8
    full_op(1'b1, 1'b1);
    chk("t4_ch0_1", VW'(v_out[1]), VW'(5));
    chk("t4_round1", VW'(round), VW'(1));
    step();

    // 5. two incs two cycles apart, v_in changed between them
    launch(1'b0, 1'b0);
    step();
    en = 1'b0;
    #1;
    chk("t5_ready_a", VW'(ready), VW'(0));
    chk("t5_pulse_a", VW'(ready_pulse), VW'(0));
    step();
    v_in = pattern(1, 100, 1, 200);
    launch(1'b0, 1'b1);
    step();
    en = 1'b0;
    #1;
    chk("t5_ready_b", VW'(ready), VW'(0));
    chk("t5_pulse_b", VW'(ready_pulse), VW'(0));
    step();
    chk("t5_ready_done", VW'(ready), VW'(1));
    chk("t5_pulse_done", VW'(ready_pulse), VW'(1));
    step();
    chk("t5_pulse_once", VW'(ready_pulse), VW'(0));
    chk("t5_round3", VW'(round), VW'(3));
    step();

    // 6. reset one cycle after an inc
    v_in = pattern(1, 0, 10, 0);
    launch(1'b1, 1'b0);
    step();
    rstb = 1'b0;
    en   = 1'b0;
    exp_q.delete();
    due_q.delete();
    cur_exp  = '0;
    tb_round = 0;
    #1;
    chk("t6_vout", v_out, '0);
    chk("t6_ready", VW'(ready), VW'(1));
    chk("t6_pulse", VW'(ready_pulse), VW'(0));
    chk("t6_round", VW'(round), VW'(0));
    step();
    rstb = 1'b1;
    step();
    step();
    step();
    chk("t6_ready_after", VW'(ready), VW'(1));
    chk("t6_round_after", VW'(round), VW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
